// File: rtl/vp_pkg.sv
// Shared types for the vector execute stage: opcodes, FSM states, modes.
// The mode decoder resolves flag priority and legality in one place.
package vp_pkg;

    localparam int LANES_D = 4;
    localparam int W_D     = 8;

    typedef enum logic [2:0] {
        OP_MOV  = 3'b000,
        OP_MOVV = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MUL  = 3'b100,
        OP_VADD = 3'b101,
        OP_DIV  = 3'b110,
        OP_NOP  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAL,
        S_LANE,
        S_DIVIT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        M_NOP,
        M_SCAL,
        M_VEC,
        M_DIV
    } mode_e;

    // operSum outranks operALUve, which outranks operALUe
    function automatic mode_e decode_mode(input op_e op, input logic sum,
                                          input logic ve, input logic e);
        mode_e m;
        m = M_NOP;
        priority case (1'b1)
            sum: if (op == OP_VADD) m = M_VEC;
            ve: begin
                if (op == OP_MOVV || op == OP_MUL) m = M_VEC;
                else if (op == OP_DIV) m = M_DIV;
            end
            e: begin
                if (op == OP_MOV || op == OP_ADD || op == OP_SUB) m = M_SCAL;
            end
            default: m = M_NOP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vector_exec_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
// Purely combinational; the top reuses it for every bit of every lane.
module restoring_div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_dbit,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic         o_qbit
);

    logic [W:0]   w_trial;
    logic [W-1:0] w_diff;

    assign w_trial = {i_rem, i_dbit};
    assign w_diff  = W'(w_trial - {1'b0, i_divisor});
    assign o_qbit  = (w_trial >= {1'b0, i_divisor});
    assign o_rem   = o_qbit ? w_diff : w_trial[W-1:0];

endmodule

// File: rtl/vector_exec_unit.sv
// Execute stage: scalar ops in one step, vector ops one lane per step,
// DIV one quotient bit per step using a single shared divider slice.
module vector_exec_unit
    import vp_pkg::*;
#(
    parameter int LANES = LANES_D,
    parameter int W     = W_D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         opALU,
    input  logic               operALUe,
    input  logic               operALUve,
    input  logic               operSum,
    input  logic [LANES*W-1:0] vecA,
    input  logic [LANES*W-1:0] vecB,
    input  logic [W-1:0]       scalA,
    input  logic [W-1:0]       scalB,
    output logic               busy,
    output logic               done,
    output logic [LANES*W-1:0] vec_res,
    output logic [W-1:0]       scal_res,
    output logic               we_vec,
    output logic               we_scal,
    output logic               div_zero,
    output logic               illegal
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    state_e r_state, w_next;
    mode_e  r_mode, w_mode;
    op_e    r_op;

    logic [LANES*W-1:0] r_va, r_vb, r_vec;
    logic [W-1:0]       r_sa, r_sb, r_scal, r_rem;
    logic [W-2:0]       r_q;
    logic [LW-1:0]      r_lane;
    logic [BW-1:0]      r_bit;
    logic               r_dz;

    logic [W-1:0] w_lane_a, w_lane_b, w_lane_res, w_scal_res, w_rem_n;
    logic         w_dbit, w_qbit, w_last_lane, w_last_bit, w_cap;

    assign w_mode      = decode_mode(op_e'(opALU), operSum, operALUve, operALUe);
    assign w_cap       = (r_state == S_IDLE) && start;
    assign w_last_lane = (r_lane == LW'(LANES - 1));
    assign w_last_bit  = (r_bit == BW'(W - 1));
    assign w_lane_a    = r_va[r_lane*W +: W];
    assign w_lane_b    = r_vb[r_lane*W +: W];
    assign w_dbit      = w_lane_a[BW'(W - 1) - r_bit];

    restoring_div_step #(.W(W)) u_div (
        .i_rem     (r_rem),
        .i_dbit    (w_dbit),
        .i_divisor (r_sb),
        .o_rem     (w_rem_n),
        .o_qbit    (w_qbit)
    );

    always_comb begin
        w_lane_res = w_lane_a;
        unique case (r_op)
            OP_MOVV: w_lane_res = r_sb;
            OP_MUL:  w_lane_res = w_lane_a * r_sb;
            OP_VADD: w_lane_res = w_lane_a + w_lane_b;
            default: w_lane_res = w_lane_a;
        endcase
    end

    always_comb begin
        w_scal_res = r_sb;
        unique case (r_op)
            OP_ADD:  w_scal_res = r_sa + r_sb;
            OP_SUB:  w_scal_res = r_sa - r_sb;
            default: w_scal_res = r_sb;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    unique case (w_mode)
                        M_SCAL:  w_next = S_SCAL;
                        M_VEC:   w_next = S_LANE;
                        M_DIV:   w_next = S_DIVIT;
                        default: w_next = S_DONE;
                    endcase
                end
            end
            S_SCAL:  w_next = S_DONE;
            S_LANE:  if (w_last_lane) w_next = S_DONE;
            S_DIVIT: if (w_last_lane && w_last_bit) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= M_NOP;
            r_op   <= OP_MOV;
            r_va   <= '0;
            r_vb   <= '0;
            r_sa   <= '0;
            r_sb   <= '0;
            r_vec  <= '0;
            r_scal <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_lane <= '0;
            r_bit  <= '0;
            r_dz   <= 1'b0;
        end else begin
            if (w_cap) begin
                r_mode <= w_mode;
                r_op   <= op_e'(opALU);
                r_va   <= vecA;
                r_vb   <= vecB;
                r_sa   <= scalA;
                r_sb   <= scalB;
                r_rem  <= '0;
                r_lane <= '0;
                r_bit  <= '0;
                r_dz   <= (w_mode == M_DIV) && (scalB == '0);
            end
            if (r_state == S_SCAL) r_scal <= w_scal_res;
            if (r_state == S_LANE) begin
                r_vec[r_lane*W +: W] <= w_lane_res;
                r_lane <= w_last_lane ? '0 : r_lane + 1'b1;
            end
            // divisor 0 always passes the trial compare, giving all-ones
            if (r_state == S_DIVIT) begin
                r_q <= {r_q[W-3:0], w_qbit};
                if (w_last_bit) begin
                    r_vec[r_lane*W +: W] <= {r_q, w_qbit};
                    r_rem  <= '0;
                    r_bit  <= '0;
                    r_lane <= w_last_lane ? '0 : r_lane + 1'b1;
                end else begin
                    r_rem <= w_rem_n;
                    r_bit <= r_bit + 1'b1;
                end
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign we_vec   = done && (r_mode == M_VEC || r_mode == M_DIV);
    assign we_scal  = done && (r_mode == M_SCAL);
    assign illegal  = done && (r_mode == M_NOP) && (r_op != OP_NOP);
    assign div_zero = r_dz;
    assign vec_res  = r_vec;
    assign scal_res = r_scal;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Bench for vector_exec_unit: directed scenarios plus random ops checked
// against a lane-wise arithmetic model of the execute stage.
module tb_vector_exec_unit;

    localparam int LANES = 4;
    localparam int W     = 8;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [2:0]  opALU;
    logic        operALUe, operALUve, operSum;
    logic [31:0] vecA, vecB;
    logic [7:0]  scalA, scalB;
    logic        busy, done, we_vec, we_scal, div_zero, illegal;
    logic [31:0] vec_res;
    logic [7:0]  scal_res;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_vec;
    logic [7:0]  m_scal;

    int          lat;
    logic [31:0] vr;
    logic [7:0]  sr;
    logic        wv, ws, il, dz, dn2, bz2;

    vector_exec_unit #(.LANES(LANES), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opALU(opALU),
        .operALUe(operALUe), .operALUve(operALUve), .operSum(operSum),
        .vecA(vecA), .vecB(vecB), .scalA(scalA), .scalB(scalB),
        .busy(busy), .done(done), .vec_res(vec_res), .scal_res(scal_res),
        .we_vec(we_vec), .we_scal(we_scal), .div_zero(div_zero),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // 0 nop, 1 scalar, 2 element-wise vector, 3 divide
    function automatic int mode_of(input logic [2:0] op, input logic e,
                                   input logic ve, input logic sm);
        if (sm) return (op == 3'd5) ? 2 : 0;
        if (ve) return (op == 3'd1 || op == 3'd4) ? 2 : (op == 3'd6) ? 3 : 0;
        if (e)  return (op == 3'd0 || op == 3'd2 || op == 3'd3) ? 1 : 0;
        return 0;
    endfunction

    function automatic int exp_lat(input int md);
        if (md == 1) return 1;
        if (md == 2) return LANES;
        if (md == 3) return LANES * W;
        return 0;
    endfunction

    task automatic model_apply(input logic [2:0] op, input logic e, ve, sm,
                               input logic [31:0] a, b,
                               input logic [7:0] sa, sb);
        int md, x, y, r;
        md = mode_of(op, e, ve, sm);
        if (md == 1) begin
            if (op == 3'd0)      r = sb;
            else if (op == 3'd2) r = sa + sb;
            else                 r = sa - sb;
            m_scal = 8'(r);
        end
        if (md >= 2) begin
            for (int i = 0; i < LANES; i++) begin
                x = a[i*8 +: 8];
                y = b[i*8 +: 8];
                if (op == 3'd5)      r = x + y;
                else if (op == 3'd1) r = sb;
                else if (op == 3'd4) r = x * sb;
                else                 r = (sb == 0) ? 255 : x / sb;
                m_vec[i*8 +: 8] = 8'(r);
            end
        end
    endtask

    // Launch at E0, scramble inputs while busy, report what done showed.
    task automatic run_op(input logic [2:0] op, input logic e, ve, sm,
                          input logic [31:0] a, b, input logic [7:0] sa, sb,
                          input bit hammer);
        opALU = op; operALUe = e; operALUve = ve; operSum = sm;
        vecA = a; vecB = b; scalA = sa; scalB = sb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            vecA = $urandom; vecB = $urandom;
            scalA = 8'($urandom); scalB = 8'($urandom);
            opALU = 3'($urandom); operALUe = 1'($urandom);
            operALUve = 1'($urandom); operSum = 1'($urandom);
            start = hammer ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        vr = vec_res; sr = scal_res;
        wv = we_vec; ws = we_scal; il = illegal; dz = div_zero;
        @(posedge clk); #1;
        dn2 = done; bz2 = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; opALU = '0;
        operALUe = 0; operALUve = 0; operSum = 0;
        vecA = '0; vecB = '0; scalA = '0; scalB = '0;
        m_vec = '0; m_scal = '0;
        #12;
        checks++;
        if ({busy, done, we_vec, we_scal, div_zero, illegal} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000",
                     {busy, done, we_vec, we_scal, div_zero, illegal});
        end
        checks++;
        if (vec_res !== 32'h0 || scal_res !== 8'h0) begin
            errors++;
            $display("FAIL reset_res got %h/%h exp 0/0", vec_res, scal_res);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_scalar_add();
        run_op(3'd2, 1, 0, 0, 32'h0, 32'h0, 8'hF0, 8'h20, 0);
        model_apply(3'd2, 1, 0, 0, 32'h0, 32'h0, 8'hF0, 8'h20);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL add_lat got %0d exp 1", lat);
        end
        checks++;
        if (sr !== 8'h10) begin
            errors++; $display("FAIL add_res got %h exp 10", sr);
        end
        checks++;
        if ({ws, wv, il} !== 3'b100) begin
            errors++; $display("FAIL add_we got %b exp 100", {ws, wv, il});
        end
        checks++;
        if (dn2 !== 1'b0 || bz2 !== 1'b0) begin
            errors++; $display("FAIL add_pulse got %b%b exp 00", dn2, bz2);
        end
    endtask

    task automatic test_vadd();
        run_op(3'd5, 0, 0, 1, 32'h04030201, 32'hFF010101, 8'h0, 8'h0, 0);
        model_apply(3'd5, 0, 0, 1, 32'h04030201, 32'hFF010101, 8'h0, 8'h0);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL vadd_lat got %0d exp 4", lat);
        end
        checks++;
        if (vr !== 32'h03040302) begin
            errors++; $display("FAIL vadd_res got %h exp 03040302", vr);
        end
        checks++;
        if ({wv, ws, dn2} !== 3'b100) begin
            errors++; $display("FAIL vadd_we got %b exp 100", {wv, ws, dn2});
        end
        checks++;
        if (sr !== m_scal) begin
            errors++; $display("FAIL vadd_hold got %h exp %h", sr, m_scal);
        end
    endtask

    task automatic test_mul();
        run_op(3'd4, 0, 1, 0, 32'h10030201, 32'h0, 8'h0, 8'h11, 0);
        model_apply(3'd4, 0, 1, 0, 32'h10030201, 32'h0, 8'h0, 8'h11);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL mul_lat got %0d exp 4", lat);
        end
        checks++;
        if (vr !== 32'h10332211) begin
            errors++; $display("FAIL mul_res got %h exp 10332211", vr);
        end
    endtask

    task automatic test_div();
        run_op(3'd6, 0, 1, 0, 32'hC8640700, 32'h0, 8'h0, 8'd7, 0);
        model_apply(3'd6, 0, 1, 0, 32'hC8640700, 32'h0, 8'h0, 8'd7);
        checks++;
        if (lat !== 32) begin
            errors++; $display("FAIL div_lat got %0d exp 32", lat);
        end
        checks++;
        if (vr !== 32'h1C0E0100) begin
            errors++; $display("FAIL div_res got %h exp 1c0e0100", vr);
        end
        checks++;
        if (dz !== 1'b0 || wv !== 1'b1) begin
            errors++; $display("FAIL div_flags got %b%b exp 01", dz, wv);
        end
        run_op(3'd6, 0, 1, 0, 32'hC8640700, 32'h0, 8'h0, 8'd0, 0);
        model_apply(3'd6, 0, 1, 0, 32'hC8640700, 32'h0, 8'h0, 8'd0);
        checks++;
        if (vr !== 32'hFFFFFFFF || lat !== 32) begin
            errors++; $display("FAIL div0_res got %h/%0d exp ffffffff/32", vr, lat);
        end
        checks++;
        if (dz !== 1'b1) begin
            errors++; $display("FAIL div0_flag got %b exp 1", dz);
        end
    endtask

    task automatic test_illegal();
        run_op(3'd4, 1, 0, 0, 32'h12345678, 32'h0, 8'h5, 8'h6, 0);
        checks++;
        if (lat !== 0 || {il, wv, ws} !== 3'b100) begin
            errors++;
            $display("FAIL ill_mul got lat %0d il/wv/ws %b exp 0 100", lat, {il, wv, ws});
        end
        checks++;
        if (vr !== m_vec || sr !== m_scal) begin
            errors++;
            $display("FAIL ill_hold got %h/%h exp %h/%h", vr, sr, m_vec, m_scal);
        end
        checks++;
        if (dz !== 1'b0) begin
            errors++; $display("FAIL ill_dzclr got %b exp 0", dz);
        end
        run_op(3'd7, 1, 0, 0, 32'h0, 32'h0, 8'h0, 8'h0, 0);
        checks++;
        if (lat !== 0 || {il, wv, ws} !== 3'b000) begin
            errors++;
            $display("FAIL nop got lat %0d il/wv/ws %b exp 0 000", lat, {il, wv, ws});
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        t1 = -1; t2 = -1;
        opALU = 3'd2; operALUe = 1; operALUve = 0; operSum = 0;
        scalA = 8'h01; scalB = 8'h02; start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (t1 < 0) t1 = c;
                else if (t2 < 0) t2 = c;
            end
        end
        start = 1'b0;
        model_apply(3'd2, 1, 0, 0, 32'h0, 32'h0, 8'h01, 8'h02);
        checks++;
        if (t1 !== 1 || t2 !== 4) begin
            errors++; $display("FAIL b2b_timing got %0d,%0d exp 1,4", t1, t2);
        end
        checks++;
        if (scal_res !== 8'h03 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_end got %h/%b exp 03/0", scal_res, busy);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic        e, ve, sm;
        logic [31:0] a, b;
        logic [7:0]  sa, sb;
        int md;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom); e = 1'($urandom);
            ve = 1'($urandom); sm = 1'($urandom);
            a = $urandom; b = $urandom; sa = 8'($urandom);
            sb = ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom);
            md = mode_of(op, e, ve, sm);
            run_op(op, e, ve, sm, a, b, sa, sb, 0);
            model_apply(op, e, ve, sm, a, b, sa, sb);
            checks++;
            if (lat !== exp_lat(md)) begin
                errors++; $display("FAIL rnd_lat op %0d got %0d exp %0d", op, lat, exp_lat(md));
            end
            checks++;
            if (vr !== m_vec || sr !== m_scal) begin
                errors++;
                $display("FAIL rnd_res op %0d got %h/%h exp %h/%h", op, vr, sr, m_vec, m_scal);
            end
            checks++;
            if ({wv, ws, il, dz} !== {md >= 2, md == 1, md == 0 && op != 3'd7,
                                      md == 3 && sb == 8'h0}) begin
                errors++; $display("FAIL rnd_flags op %0d got %b", op, {wv, ws, il, dz});
            end
            checks++;
            if (dn2 !== 1'b0 || bz2 !== 1'b0) begin
                errors++; $display("FAIL rnd_pulse got %b%b exp 00", dn2, bz2);
            end
        end
    endtask

    task automatic test_robust();
        logic [31:0] a;
        logic [7:0]  sb;
        int ndone;
        a  = $urandom;
        sb = 8'($urandom_range(1, 255));
        run_op(3'd6, 0, 1, 0, a, 32'h0, 8'h0, sb, 1);
        model_apply(3'd6, 0, 1, 0, a, 32'h0, 8'h0, sb);
        checks++;
        if (lat !== 32 || vr !== m_vec || dn2 !== 1'b0) begin
            errors++;
            $display("FAIL hammer got lat %0d res %h exp 32 %h", lat, vr, m_vec);
        end
        opALU = 3'd6; operALUe = 0; operALUve = 1; operSum = 0;
        vecA = $urandom; scalB = 8'h0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_vec = '0; m_scal = '0;
        checks++;
        if ({busy, done, we_vec, we_scal, div_zero, illegal} !== 6'b0 ||
            vec_res !== 32'h0 || scal_res !== 8'h0) begin
            errors++;
            $display("FAIL midrst got %b %h %h exp 0",
                     {busy, done, we_vec, we_scal, div_zero, illegal}, vec_res, scal_res);
        end
        ndone = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done === 1'b1 || we_vec === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++; $display("FAIL midrst_done got %0d exp 0", ndone);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd3, 1, 0, 0, 32'h0, 32'h0, 8'h05, 8'h07, 0);
        checks++;
        if (lat !== 1 || sr !== 8'hFE || vr !== 32'h0) begin
            errors++; $display("FAIL post_rst got %0d %h %h exp 1 fe 0", lat, sr, vr);
        end
    endtask

    initial begin
        test_reset();
        test_scalar_add();
        test_vadd();
        test_mul();
        test_div();
        test_illegal();
        test_back_to_back();
        test_random();
        test_robust();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
